multicycle_adder: RTL and testbench
===================================

Name: multicycle_adder

Overview:
- Parametrised, area-lean N-bit adder/subtractor that processes operands in W-bit slices, one slice per clock.
- A registered carry links consecutive slices.
- Valid/ready handshake on both input and output sides, so it drops into streaming datapaths.
- Successor to the team's combinational adders: adds subtract mode, signed-overflow flag, back-pressure and multi-cycle sequencing.

Parameters:
- N, 32, operand/result width in bits; must be a multiple of W.
- W, 8, slice width added per cycle; 1 <= W <= N.
- S (localparam), N/W, number of slice cycles per operation.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set presented.
- in_ready  out  1  block can accept operands.
- a  in  N  operand A.
- b  in  N  operand B.
- ci  in  1  carry-in; ignored when sub=1.
- sub  in  1  0: a+b+ci; 1: a-b, computed as a+~b+1.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- sum  out  N  registered result.
- co  out  1  carry-out of MSB; for sub, 1 means no borrow.
- ovf  out  1  two's-complement signed overflow.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high. Every register clears on the rising clk edge where reset=1.
- Reset values: state=IDLE, sum=0, co=0, ovf=0, out_valid=0, slice counter=0. in_ready is forced 0 while reset=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture a, beff=(sub ? ~b : b) and carry=(sub ? 1 : ci).
  - Clear counter k to 0 and go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle: sum[k*W +: W] <= a[k*W +: W] + beff[k*W +: W] + carry; carry <= slice carry-out; k <= k+1.
  - On the edge where k==S-1, register co=final carry and ovf=(a[N-1]==beff[N-1]) && (result[N-1]!=a[N-1]), then go to DONE.
- DONE:
  - out_valid=1; sum, co and ovf are held stable.
  - When out_ready=1, go to IDLE on that edge and drop out_valid.
  - in_valid is ignored until the block is back in IDLE.
- Timing:
  - Latency: out_valid rises exactly S cycles after the accepting edge.
  - Minimum initiation interval: S+2 cycles.
- Boundaries:
  - W==N (S=1): a single RUN cycle.
  - Back-pressure: DONE holds indefinitely; no result is ever lost or overwritten.
  - Reset in RUN or DONE discards the operation. Outputs take reset values on that edge, and the next accepted operation computes correctly.
  - sum bits of slices not yet written during RUN are don't-care. Only sum values seen while out_valid=1 are checked.
  - Counter width is $clog2(S) with a minimum of 1 bit; k never exceeds S-1.

Optional Feature:
- Macro: MULTICYCLE_ADDER_SAT_EN.
- Defined:
  - When ovf=1, sum is replaced on the final RUN edge by the signed limit: 0x7F..F if a[N-1]==0, else 0x80..0.
  - co and ovf still report the raw result.
- Undefined: sum is the wrapped N-bit result; no saturation logic is synthesised.

Decomposition:
- Shared package / include (adder_pkg):
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
  - helper function computing the counter width.
- One natural sub-module: slice_adder, a combinational W-bit a+b+ci yielding {co, sum}. It is instantiated once and reused every RUN cycle.

Test Plan (N=16, W=4, S=4):
1. a=0x1234, b=0x1111, ci=0, sub=0 -> sum=0x2345, co=0, ovf=0; out_valid exactly 4 cycles after accept.
2. a=0xFFFF, b=0x0001, ci=0 -> sum=0x0000, co=1, ovf=0 (carry ripples through all 4 slices). Also a=0x0000, b=0x0000, ci=1 -> sum=0x0001.
3. a=0x7FFF, b=0x0001, sub=0 -> ovf=1, co=0; sum=0x8000 without SAT_EN, 0x7FFF with SAT_EN. Also a=0x8000, b=0x0001, sub=1 -> ovf=1; sum 0x7FFF without, 0x8000 with.
4. a=0x0005, b=0x0007, sub=1, ci=1 -> sum=0xFFFE, co=0, ovf=0 (ci ignored). Also a=0x0007, b=0x0005, sub=1 -> sum=0x0002, co=1.
5. Hold out_ready=0 for 6 cycles in DONE while in_valid=1 with new operands -> sum/co/ovf stable, in_ready=0, nothing captured. Then out_ready=1 -> IDLE next cycle, and new operands accepted.
6. Assert reset for one cycle after 2 RUN cycles -> next cycle state IDLE, out_valid=0, sum=0, in_ready=1. Then a=0x00FF, b=0x0001 -> sum=0x0100.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the multicycle adder: FSM state encoding and
// the slice-counter width helper.
package adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // A single-slice configuration still needs a one-bit counter.
   function automatic int cnt_width(input int slices);
      return (slices <= 1) ? 1 : $clog2(slices);
   endfunction

endpackage

// File: rtl/slice_adder.sv
// Combinational W-bit adder slice: {co, sum} = a + b + ci.
module slice_adder #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         ci,
   output logic [W-1:0] sum,
   output logic         co
);

   assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};

endmodule

// File: rtl/multicycle_adder.sv
// N-bit adder/subtractor that works on one W-bit slice per clock with
// valid/ready handshakes. Define MULTICYCLE_ADDER_SAT_EN to saturate on overflow.
module multicycle_adder
   import adder_pkg::*;
#(
   parameter int N = 32,
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   input  logic         sub,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] sum,
   output logic         co,
   output logic         ovf
);

   localparam int S  = N / W;
   localparam int KW = cnt_width(S);
   localparam logic [KW-1:0] K_LAST = KW'(S - 1);

   state_t        state, state_nxt;
   logic [N-1:0]  a_q, b_q;
   logic          carry_q;
   logic [KW-1:0] k;
   logic [W-1:0]  slice_sum;
   logic          slice_co;
   logic          last;
   logic          accept;
   logic          ovf_raw;

   slice_adder #(.W(W)) u_slice (
      .a   (a_q[k*W +: W]),
      .b   (b_q[k*W +: W]),
      .ci  (carry_q),
      .sum (slice_sum),
      .co  (slice_co)
   );

   assign last    = (k == K_LAST);
   assign accept  = in_valid && in_ready;
   // On the last slice, the slice MSB is the MSB of the full result.
   assign ovf_raw = (a_q[N-1] == b_q[N-1]) && (slice_sum[W-1] != a_q[N-1]);

   always_comb begin
      // NOTE: every output gets a default first so no path leaves a latch.
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = !reset;
            if (in_valid && !reset) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (last) state_nxt = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         a_q     <= '0;
         b_q     <= '0;
         carry_q <= 1'b0;
         k       <= '0;
         sum     <= '0;
         co      <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? 1'b1 : ci;
                  k       <= '0;
               end
            end
            ST_RUN: begin
               sum[k*W +: W] <= slice_sum;
               carry_q       <= slice_co;
               if (!last) begin
                  k <= k + 1'b1;
               end else begin
                  co  <= slice_co;
                  ovf <= ovf_raw;
`ifdef MULTICYCLE_ADDER_SAT_EN
                  // Later assignment wins over the slice write above.
                  if (ovf_raw) sum <= {a_q[N-1], {(N-1){~a_q[N-1]}}};
`endif
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed self-checking bench for multicycle_adder at N=16, W=4 (S=4).
// Expected sums follow MULTICYCLE_ADDER_SAT_EN when it is defined.
module tb_multicycle_adder;

   localparam int N = 16;
   localparam int W = 4;
   localparam int S = N / W;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [N-1:0] a, b;
   logic         ci, sub;
   logic         out_valid;
   logic         out_ready;
   logic [N-1:0] sum;
   logic         co, ovf;

   int n_checks = 0;
   int n_errors = 0;

   multicycle_adder #(.N(N), .W(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .co        (co),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present operands and hold them until the accepting edge.
   task automatic accept_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                            input logic civ, input logic subv);
      int n = 0;
      a = av; b = bv; ci = civ; sub = subv; in_valid = 1'b1;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (!in_ready) check({tag, "_ready_timeout"}, 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
   endtask

   // Count cycles from the accepting edge until out_valid rises.
   task automatic wait_result(output int lat);
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
   endtask

   task automatic release_result(input string tag);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] av, input logic [N-1:0] bv,
                         input logic civ, input logic subv, input logic [N-1:0] exp_sum,
                         input logic exp_co, input logic exp_ovf);
      int lat;
      accept_op(tag, av, bv, civ, subv);
      wait_result(lat);
      check({tag, "_latency"}, 32'(lat), 32'(S));
      check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
      check({tag, "_co"}, 32'(co), 32'(exp_co));
      check({tag, "_ovf"}, 32'(ovf), 32'(exp_ovf));
      release_result(tag);
   endtask

   logic [N-1:0] sat_pos, sat_neg;
   int           lat;

   initial begin
`ifdef MULTICYCLE_ADDER_SAT_EN
      sat_pos = 16'h7FFF;
      sat_neg = 16'h8000;
`else
      sat_pos = 16'h8000;
      sat_neg = 16'h7FFF;
`endif
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; ci = 1'b0; sub = 1'b0;
      tick();
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_sum", 32'(sum), 32'd0);
      check("rst_co", 32'(co), 32'd0);
      check("rst_ovf", 32'(ovf), 32'd0);
      reset = 1'b0;
      #1;
      check("idle_in_ready", 32'(in_ready), 32'd1);

      run_op("t1_add",     16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);
      run_op("t2_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_op("t2_cin",     16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0, 1'b0);
      run_op("t3_ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, sat_pos,  1'b0, 1'b1);
      run_op("t3_ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, sat_neg,  1'b1, 1'b1);
      run_op("t4_borrow",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_op("t4_noborr",  16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0);

      // Back-pressure: new operands offered while the result is held.
      accept_op("t5", 16'h1234, 16'h1111, 1'b0, 1'b0);
      wait_result(lat);
      check("t5_latency", 32'(lat), 32'(S));
      a = 16'hAAAA; b = 16'h5555; ci = 1'b0; sub = 1'b0; in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         check("t5_hold_valid", 32'(out_valid), 32'd1);
         check("t5_hold_ready", 32'(in_ready), 32'd0);
         check("t5_hold_sum", 32'(sum), 32'h2345);
         check("t5_hold_co", 32'(co), 32'd0);
         check("t5_hold_ovf", 32'(ovf), 32'd0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("t5_idle_valid", 32'(out_valid), 32'd0);
      check("t5_idle_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      wait_result(lat);
      check("t5_next_latency", 32'(lat), 32'(S));
      check("t5_next_sum", 32'(sum), 32'hFFFF);
      check("t5_next_co", 32'(co), 32'd0);
      check("t5_next_ovf", 32'(ovf), 32'd0);
      release_result("t5_next");

      // Reset after two RUN cycles discards the operation.
      accept_op("t6", 16'h1234, 16'h1111, 1'b0, 1'b0);
      tick();
      tick();
      reset = 1'b1;
      #1;
      check("t6_rst_in_ready", 32'(in_ready), 32'd0);
      tick();
      reset = 1'b0;
      #1;
      check("t6_out_valid", 32'(out_valid), 32'd0);
      check("t6_sum", 32'(sum), 32'd0);
      check("t6_in_ready", 32'(in_ready), 32'd1);
      run_op("t6_after", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
